// File: rtl/serial_pkg.sv
// Shared types for the digit-serial add/subtract unit: FSM state encoding and mode values.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WORK = 2'b01,
    DONE = 2'b11
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/serial_digit_adder.sv
// Combinational DIGIT-bit ripple slice: s = x + y + cin, with carry out.
module serial_digit_adder #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout
);

  assign {cout, s} = {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, cin};

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor: consumes DIGIT bits per clock, WIDTH/DIGIT clocks per operation,
// with busy/done handshake, borrow/carry in result[WIDTH] and a signed overflow flag.
module serial_addsub
  import serial_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   result,
  output logic             ovf
);

  localparam int S  = WIDTH / DIGIT;
  localparam int CW = $clog2(S) + 1;

  if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("serial_addsub: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  state_t          state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic [WIDTH-1:0] sum_next;
  logic             carry;
  logic             mode;
  logic             a_msb;
  logic             bp_msb;
  logic [CW-1:0]    cnt;
  logic [DIGIT-1:0] y_dig;
  logic [DIGIT-1:0] s_dig;
  logic             cout;

  // Subtraction is a + ~b + 1; the +1 comes from loading carry with the mode bit.
  assign y_dig = (mode == MODE_SUB) ? ~b_sh[DIGIT-1:0] : b_sh[DIGIT-1:0];

  serial_digit_adder #(.DIGIT(DIGIT)) u_digit (
    .x    (a_sh[DIGIT-1:0]),
    .y    (y_dig),
    .cin  (carry),
    .s    (s_dig),
    .cout (cout)
  );

  if (DIGIT == WIDTH) begin : g_single_digit
    assign sum_next = s_dig;
  end else begin : g_multi_digit
    assign sum_next = {s_dig, sum_sh[WIDTH-1:DIGIT]};
  end

  assign busy = (state == WORK);
  assign done = (state == DONE);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      mode   <= MODE_ADD;
      a_msb  <= 1'b0;
      bp_msb <= 1'b0;
      cnt    <= '0;
      result <= '0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_sh   <= a;
            b_sh   <= b;
            mode   <= sub;
            carry  <= sub;
            a_msb  <= a[WIDTH-1];
            bp_msb <= b[WIDTH-1] ^ sub;
            cnt    <= '0;
            state  <= WORK;
          end else begin
            state <= IDLE;
          end
        end
        WORK: begin
          a_sh   <= a_sh >> DIGIT;
          b_sh   <= b_sh >> DIGIT;
          sum_sh <= sum_next;
          carry  <= cout;
          cnt    <= cnt + 1'b1;
          // Last digit: publish the full result and flags in the same edge.
          if (cnt == CW'(S - 1)) begin
            result <= {(mode == MODE_ADD) ? cout : ~cout, sum_next};
            ovf    <= (a_msb == bp_msb) && (sum_next[WIDTH-1] != a_msb);
            state  <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Randomised and directed bench for serial_addsub across three WIDTH/DIGIT configurations,
// checked against an arithmetic reference model.
module tb_serial_addsub;

  logic        clock = 1'b0;
  logic        resetn;
  logic        st8, st84, st16;
  logic        sub;
  logic [15:0] a, b;
  logic        busy8, done8, ovf8;
  logic        busy84, done84, ovf84;
  logic        busy16, done16, ovf16;
  logic [8:0]  result8, result84;
  logic [16:0] result16;

  int checks = 0;
  int failures = 0;
  logic [8:0] last8;

  always #5 clock = ~clock;

  serial_addsub #(.WIDTH(8), .DIGIT(1)) dut8 (
    .clock(clock), .resetn(resetn), .start(st8), .sub(sub), .a(a[7:0]), .b(b[7:0]),
    .busy(busy8), .done(done8), .result(result8), .ovf(ovf8));

  serial_addsub #(.WIDTH(8), .DIGIT(4)) dut84 (
    .clock(clock), .resetn(resetn), .start(st84), .sub(sub), .a(a[7:0]), .b(b[7:0]),
    .busy(busy84), .done(done84), .result(result84), .ovf(ovf84));

  serial_addsub #(.WIDTH(16), .DIGIT(2)) dut16 (
    .clock(clock), .resetn(resetn), .start(st16), .sub(sub), .a(a), .b(b),
    .busy(busy16), .done(done16), .result(result16), .ovf(ovf16));

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Returns {ovf, result} for a w-bit operation, using plain integer arithmetic.
  function automatic logic [17:0] model(input int w, input logic [15:0] x, input logic [15:0] y,
                                        input logic s);
    longint full, half, ux, uy, sx, sy, r, sr;
    logic   ov;
    full = longint'(1) << w;
    half = full >> 1;
    ux = longint'(x) & (full - 1);
    uy = longint'(y) & (full - 1);
    sx = (ux >= half) ? ux - full : ux;
    sy = (uy >= half) ? uy - full : uy;
    if (!s) begin
      r  = ux + uy;
      sr = sx + sy;
    end else begin
      r = (ux - uy) & (full - 1);
      if (ux < uy) r = r + full;
      sr = sx - sy;
    end
    ov = (sr >= half) || (sr < -half);
    return {ov, r[16:0]};
  endfunction

  task automatic run_op(input logic [15:0] x, input logic [15:0] y, input logic s, input bit stray);
    logic [17:0] e8, e16;
    int k8, k84, k16, nb8, nd8;
    e8 = model(8, x, y, s);
    e16 = model(16, x, y, s);
    k8 = -1; k84 = -1; k16 = -1; nb8 = 0; nd8 = 0;
    @(negedge clock);
    a = x; b = y; sub = s; st8 = 1'b1; st84 = 1'b1; st16 = 1'b1;
    @(posedge clock);
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      if (busy8) nb8++;
      if (done8) begin
        nd8++;
        if (k8 < 0) begin
          k8 = k;
          check_val("res8", result8, e8[8:0]);
          check_val("ovf8", ovf8, e8[17]);
        end
      end
      if (done84 && k84 < 0) begin
        k84 = k;
        check_val("res84", result84, e8[8:0]);
        check_val("ovf84", ovf84, e8[17]);
      end
      if (done16 && k16 < 0) begin
        k16 = k;
        check_val("res16", result16, e16[16:0]);
        check_val("ovf16", ovf16, e16[17]);
      end
      if (k == 1) check_val("hold8", result8, last8);
      if (k == 0) begin
        st8 = 1'b0; st84 = 1'b0; st16 = 1'b0;
        a = 16'($urandom); b = 16'($urandom); sub = ~s;
      end
      if (stray && k == 3) begin st8 = 1'b1; a = ~x; end
      if (k == 4) st8 = 1'b0;
    end
    check_val("lat8", k8, 8);
    check_val("lat84", k84, 2);
    check_val("lat16", k16, 8);
    check_val("busy8", nb8, 8);
    check_val("pulse8", nd8, 1);
    last8 = e8[8:0];
  endtask

  task automatic back_to_back(input logic [7:0] x1, input logic [7:0] y1, input logic s1,
                              input logic [7:0] x2, input logic [7:0] y2, input logic s2);
    logic [17:0] e1, e2;
    int first, second;
    e1 = model(8, {8'h0, x1}, {8'h0, y1}, s1);
    e2 = model(8, {8'h0, x2}, {8'h0, y2}, s2);
    first = -1; second = -1;
    @(negedge clock);
    a = {8'h0, x1}; b = {8'h0, y1}; sub = s1; st8 = 1'b1;
    @(posedge clock);
    for (int k = 0; k < 22; k++) begin
      @(negedge clock);
      if (done8) begin
        if (first < 0) begin
          first = k;
          check_val("b2b_res1", result8, e1[8:0]);
          check_val("b2b_ovf1", ovf8, e1[17]);
        end else if (second < 0) begin
          second = k;
          check_val("b2b_res2", result8, e2[8:0]);
          check_val("b2b_ovf2", ovf8, e2[17]);
        end
      end
      if (k == 9) begin
        check_val("b2b_noidle", busy8, 1'b1);
        st8 = 1'b0;
      end
      if (k == 0) begin a = {8'h0, x2}; b = {8'h0, y2}; sub = s2; end
    end
    check_val("b2b_first", first, 8);
    check_val("b2b_gap", second - first, 9);
    last8 = e2[8:0];
  endtask

  initial begin
    int nd;
    st8 = 1'b0; st84 = 1'b0; st16 = 1'b0; sub = 1'b0; a = '0; b = '0;
    resetn = 1'b1;
    #1 resetn = 1'b0;
    #1;
    check_val("rst_busy", busy8, 1'b0);
    check_val("rst_done", done8, 1'b0);
    check_val("rst_res", result8, 9'h0);
    check_val("rst_ovf", ovf8, 1'b0);
    check_val("rst_res16", result16, 17'h0);
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    last8 = '0;

    run_op(16'd200, 16'd100, 1'b0, 1'b0);
    check_val("add_200_100", result8, 9'h12C);
    run_op(16'd5, 16'd7, 1'b1, 1'b1);
    check_val("sub_5_7", result8, 9'h1FE);
    run_op(16'd7, 16'd5, 1'b1, 1'b0);
    check_val("sub_7_5", result8, 9'h002);
    run_op(16'd127, 16'd1, 1'b0, 1'b0);
    check_val("add_127_1", {ovf8, result8}, 10'h280);
    run_op(16'h0080, 16'h0001, 1'b1, 1'b0);
    check_val("sub_80_1", {ovf8, result8}, 10'h27F);
    run_op(16'h00FF, 16'h0001, 1'b0, 1'b0);
    check_val("add84_ff_1", result84, 9'h100);
    run_op(16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
    check_val("add16_ffff", result16, 17'h1FFFE);

    for (int i = 0; i < 25; i++)
      run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));

    back_to_back(8'd100, 8'd27, 1'b0, 8'd3, 8'd9, 1'b1);

    // Abandon an operation part-way through.
    @(negedge clock);
    a = 16'h0055; b = 16'h0033; sub = 1'b0; st8 = 1'b1;
    @(posedge clock);
    @(negedge clock) st8 = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1 resetn = 1'b0;
    #1;
    check_val("mid_busy", busy8, 1'b0);
    check_val("mid_done", done8, 1'b0);
    check_val("mid_res", result8, 9'h0);
    check_val("mid_ovf", ovf8, 1'b0);
    nd = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      if (done8) nd++;
    end
    resetn = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (done8) nd++;
    end
    check_val("mid_nodone", nd, 0);
    last8 = '0;
    run_op(16'd1, 16'd1, 1'b0, 1'b0);
    check_val("after_rst", result8, 9'h002);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
